smi_mem_lib_write_multi_burst: RTL
==================================

Name: smi_mem_lib_write_multi_burst

Overview:
Parametrised successor to the single-burst SMI write core. Accepts one write transfer of arbitrary length (address, byte count, options), splits it into aligned SMI write bursts and injects a write request header per burst. It tracks up to MaxOutstanding unacknowledged bursts and returns one aggregated done/status per transfer. Sits between user write kernels and the SMI memory arbiter.

Parameters:
FifoSize, 16, internal FIFO depth for the header injector (3..128).
MaxBurstBytes, 256, maximum burst size in bytes; power of two, 8..4096; bursts never cross a MaxBurstBytes boundary, so never cross 4 KiB.
MaxOutstanding, 4, maximum issued-but-unacknowledged bursts (1..15).

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
paramsValid  in  1  transfer request valid
paramAddr  in  64  start byte address; must be 8-byte aligned
paramLen  in  32  transfer length in bytes; multiple of 8, non-zero
paramOpts  in  8  write options, copied into every burst header
paramsStop  out  1  transfer request backpressure
writeValid/writeEofc/writeData  in  1/8/64  write data stream; the whole transfer is one input frame
writeStop  out  1  write data backpressure
doneValid  out  1  transfer complete
doneStatusOk  out  1  1 = every burst acknowledged OK and no framing error
doneStop  in  1  done backpressure
smiReqValid/smiReqEofc/smiReqData  out  1/8/64  SMI request frames
smiReqStop  in  1
smiRespValid/smiRespEofc/smiRespData  in  1/8/64  SMI response frames
smiRespStop  out  1

Behaviour:
- Reset (rstn low, asynchronous): state Idle; paramsStop=1, writeStop=1, doneValid=0, doneStatusOk=0, smiReqValid=0, smiRespStop=1; all counters 0. Mid-transfer reset abandons the transfer; no done is produced.
- Handshake on every port: a transfer occurs on a cycle with valid=1 and stop=0. Eofc=0 marks a non-final word; 1..8 gives the valid byte count of the final word.
- Issue FSM states: Idle, Header, Data, Drain, WaitResp, Done.
- Idle: paramsStop=0. On accept, register addr, remaining=paramLen, opts; clear errFlag and issued count; go to Header. If paramLen=0 or addr[2:0]!=0 or len[2:0]!=0, set errFlag and go to Drain.
- Header: burstBytes = min(remaining, MaxBurstBytes - (addr mod MaxBurstBytes)). Present the header {burstBytes[15:0], addr, 16'h0000, opts, 8'h01} to the injector. Stall while outstanding==MaxOutstanding. On accept: outstanding+1, issued+1, go to Data.
- Data: pass writeData through to the injector with a word counter. Output eofc=8 on the last word of the burst, 0 otherwise. Then addr+=burstBytes and remaining-=burstBytes. Go to Header if remaining!=0, else WaitResp.
- Input eofc!=0 before the final word: set errFlag, close the current burst with eofc=8 on that word, go to WaitResp. Input eofc=0 on the final word: set errFlag, go to Drain.
- Drain: writeStop=0; discard input until eofc!=0, then go to WaitResp.
- WaitResp: wait for outstanding==0, then go to Done.
- Done: doneValid=1 and doneStatusOk = ~errFlag & respOk, held until ~doneStop, then go to Idle.
- Response side (independent): the first word of each frame is checked. It is OK iff byte0==8'hFE and bit9==0; otherwise respOk is cleared (respOk is set to 1 on each Idle accept). The rest of the frame is drained to eofc!=0, then outstanding-1. smiRespStop=0 always except in reset.
- Simultaneous issue and response in one cycle: outstanding is unchanged.
- Address arithmetic is 64-bit with wrap-around at 2^64 (no error). Counter widths: outstanding ceil(log2(MaxOutstanding+1)), word counter log2(MaxBurstBytes/8)+1.
- Minimum latency from the last burst acknowledgement to doneValid: 1 cycle.

Decomposition:
- Shared package constants: WRITE_REQ_ID_BYTE 8'h01, WRITE_RESP_ID_BYTE 8'hFE, SMI_MEM_WRITE_OPT_DEFAULT/DIRECT, response error bit index 9.
- Header insertion: reuse the existing smiHeaderInjectPf2 (8, 14, FifoSize). Its srst is driven by an internal 2-flop reset synchroniser (asserts asynchronously from rstn, deasserts synchronously).
- One natural sub-module: smi_mem_lib_write_resp_tracker. It contains the response check, drain, the outstanding counter and respOk.

Test Plan:
- addr 0x1000, len 64, MaxBurstBytes 256 -> one burst: header len 64, 8 data words, last eofc=8; OK response -> doneStatusOk=1.
- addr 0x10F0, len 0x120 -> bursts (0x10F0,16), (0x1100,256), (0x1200,16); three OK responses -> one done, doneStatusOk=1.
- MaxOutstanding=2, len 1024 at 0x0, responses withheld -> third header stalls until the first response; final done after 4 responses.
- Second response has bit9=1 -> doneStatusOk=0; remaining bursts are still issued and done is produced once.
- Input eofc=8 on word 3 of an expected 8-word transfer -> burst closed at word 3, errFlag set, doneStatusOk=0. Also: len=12 -> no SMI request, input drained, done with doneStatusOk=0.
- rstn pulsed low mid-Data with smiReqStop=1 -> outputs return to reset values immediately; a new transfer after reset completes normally.

Source files
------------

// File: rtl/smi_mem_lib_write_multi_burst_pkg.sv
// Shared constants and types for the multi-burst SMI write core.
package smi_mem_lib_write_multi_burst_pkg;
  localparam logic [7:0] WRITE_REQ_ID_BYTE         = 8'h01;
  localparam logic [7:0] WRITE_RESP_ID_BYTE        = 8'hFE;
  localparam logic [7:0] SMI_MEM_WRITE_OPT_DEFAULT = 8'h00;
  localparam logic [7:0] SMI_MEM_WRITE_OPT_DIRECT  = 8'h01;
  localparam int         RESP_ERR_BIT              = 9;
  localparam int         HDR_BYTES                 = 14;
  localparam int         DATA_BYTES                = 8;

  typedef enum logic [2:0] {Idle, Header, Data, Drain, WaitResp, Done} wrState_t;

  typedef struct packed {
    logic [15:0] burstLen;
    logic [63:0] addr;
    logic [15:0] rsvd;
    logic [7:0]  opts;
    logic [7:0]  id;
  } wrHdr_t;

  function automatic logic respWordOk(input logic [15:0] w);
    return (w[7:0] == WRITE_RESP_ID_BYTE) && !w[RESP_ERR_BIT];
  endfunction
endpackage

// File: rtl/smiHeaderInjectPf2.sv
// Queues burst headers and emits each one as whole words ahead of its payload frame.
module smiHeaderInjectPf2 #(
  parameter int DataBytes   = 8,
  parameter int HeaderBytes = 14,
  parameter int FifoSize    = 16
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     hdrValid,
  input  logic [HeaderBytes*8-1:0] hdrData,
  output logic                     hdrStop,
  input  logic                     inValid,
  input  logic [7:0]               inEofc,
  input  logic [DataBytes*8-1:0]   inData,
  output logic                     inStop,
  output logic                     outValid,
  output logic [7:0]               outEofc,
  output logic [DataBytes*8-1:0]   outData,
  input  logic                     outStop
);
  localparam int DW   = DataBytes * 8;
  localparam int HW   = (HeaderBytes + DataBytes - 1) / DataBytes;
  localparam int PADW = HW * DW;
  localparam int IW   = (HW > 1) ? $clog2(HW) : 1;
  localparam int PW   = $clog2(FifoSize);
  localparam int CW   = $clog2(FifoSize + 1);

  logic [HeaderBytes*8-1:0] mem [FifoSize];
  logic [PW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] count;
  logic [IW-1:0] hdrIdx;
  logic          inPayload;
  logic [PADW-1:0] headPad;
  logic push, pop, hdrWordTaken;

  // Header is zero-padded to whole words so the payload keeps its word alignment.
  assign headPad      = PADW'(mem[rdPtr]);
  assign hdrStop      = (count == CW'(FifoSize));
  assign push         = hdrValid & ~hdrStop;
  assign hdrWordTaken = ~inPayload & (count != '0) & ~outStop;
  assign pop          = hdrWordTaken & (hdrIdx == IW'(HW - 1));

  assign outValid = inPayload ? inValid : (count != '0);
  assign outData  = inPayload ? inData  : headPad[hdrIdx*DW +: DW];
  assign outEofc  = inPayload ? inEofc  : 8'd0;
  assign inStop   = ~inPayload | outStop;

  always_ff @(posedge clk)
    if (push) mem[wrPtr] <= hdrData;

  always_ff @(posedge clk) begin
    if (srst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      hdrIdx    <= '0;
      inPayload <= 1'b0;
    end else begin
      if (push) wrPtr <= (wrPtr == PW'(FifoSize - 1)) ? '0 : wrPtr + 1'b1;
      if (pop)  rdPtr <= (rdPtr == PW'(FifoSize - 1)) ? '0 : rdPtr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (hdrWordTaken) hdrIdx <= pop ? '0 : hdrIdx + 1'b1;
      if (pop) inPayload <= 1'b1;
      else if (inPayload & inValid & ~outStop & (inEofc != 8'd0)) inPayload <= 1'b0;
    end
  end
endmodule

// File: rtl/smi_mem_lib_write_multi_burst_resp_tracker.sv
// Checks write response frames and tracks bursts still awaiting acknowledgement.
module smi_mem_lib_write_resp_tracker
  import smi_mem_lib_write_multi_burst_pkg::*;
#(
  parameter int MaxOutstanding = 4,
  parameter int OW             = $clog2(MaxOutstanding + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          issue,
  input  logic          clrOk,
  input  logic          respValid,
  input  logic [7:0]    respEofc,
  input  logic [63:0]   respData,
  output logic [OW-1:0] outstanding,
  output logic          allAckedNext,
  output logic          respOk
);
  logic inFrame, frameEnd, dec;
  logic unusedRespBits;

  assign unusedRespBits = ^respData[63:16];
  assign frameEnd     = respValid & (respEofc != 8'd0);
  assign dec          = frameEnd & (outstanding != '0);
  // Looks one cycle ahead so done can follow the last ack without a bubble.
  assign allAckedNext = (outstanding + OW'(issue) - OW'(dec)) == '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inFrame     <= 1'b0;
      outstanding <= '0;
      respOk      <= 1'b0;
    end else begin
      if (respValid) inFrame <= (respEofc == 8'd0);
      if (clrOk) respOk <= 1'b1;
      else if (respValid & ~inFrame & ~respWordOk(respData[15:0])) respOk <= 1'b0;
      outstanding <= outstanding + OW'(issue) - OW'(dec);
    end
  end
endmodule

// File: rtl/smi_mem_lib_write_multi_burst.sv
// Splits one write transfer into aligned SMI bursts and returns one aggregated done.
module smi_mem_lib_write_multi_burst
  import smi_mem_lib_write_multi_burst_pkg::*;
#(
  parameter int FifoSize       = 16,
  parameter int MaxBurstBytes  = 256,
  parameter int MaxOutstanding = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        paramsValid,
  input  logic [63:0] paramAddr,
  input  logic [31:0] paramLen,
  input  logic [7:0]  paramOpts,
  output logic        paramsStop,
  input  logic        writeValid,
  input  logic [7:0]  writeEofc,
  input  logic [63:0] writeData,
  output logic        writeStop,
  output logic        doneValid,
  output logic        doneStatusOk,
  input  logic        doneStop,
  output logic        smiReqValid,
  output logic [7:0]  smiReqEofc,
  output logic [63:0] smiReqData,
  input  logic        smiReqStop,
  input  logic        smiRespValid,
  input  logic [7:0]  smiRespEofc,
  input  logic [63:0] smiRespData,
  output logic        smiRespStop
);
  localparam int OW = $clog2(MaxOutstanding + 1);
  localparam int WC = $clog2(MaxBurstBytes / 8) + 1;
  localparam int BW = $clog2(MaxBurstBytes) + 1;

  logic [1:0]  rstSync;
  logic        srst;
  wrState_t    state;
  logic [63:0] addr;
  logic [31:0] remaining, issued;
  logic [7:0]  opts;
  logic        errFlag, respOk, allAckedNext;
  logic [WC-1:0] wordCnt;
  logic [15:0] burstLen, burstBytes;
  logic [BW-1:0] room;
  logic [OW-1:0] outstanding;
  wrHdr_t      hdr;
  logic hdrValid, hdrStop, issue, accept, badParams;
  logic dataValid, injInStop, dataTake, lastW, finalW;
  logic [7:0] injEofc;
  logic injOutValid;
  logic unusedIssued;

  // Injector reset asserts with rstn and releases two clocks later.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) rstSync <= 2'b11;
    else       rstSync <= {rstSync[0], 1'b0};
  assign srst = rstSync[1];

  assign room       = BW'(MaxBurstBytes) - {1'b0, addr[BW-2:0]};
  assign burstBytes = (remaining < 32'(room)) ? remaining[15:0] : 16'(room);
  assign hdr        = '{burstLen: burstBytes, addr: addr, rsvd: 16'h0000,
                        opts: opts, id: WRITE_REQ_ID_BYTE};

  assign paramsStop = (state != Idle) | srst;
  assign accept     = paramsValid & ~paramsStop;
  assign badParams  = (paramLen == 32'd0) | (paramAddr[2:0] != 3'd0) | (paramLen[2:0] != 3'd0);
  assign hdrValid   = (state == Header) & (outstanding != OW'(MaxOutstanding));
  assign issue      = hdrValid & ~hdrStop;

  assign lastW     = (WC'(burstLen >> 3) == wordCnt + 1'b1);
  assign finalW    = lastW & (remaining == 32'(burstLen));
  assign dataValid = (state == Data) & writeValid;
  assign dataTake  = dataValid & ~injInStop;
  assign injEofc   = (lastW | (writeEofc != 8'd0)) ? 8'd8 : 8'd0;
  assign writeStop = (state == Data) ? injInStop : (state != Drain);

  assign doneValid    = (state == Done);
  assign doneStatusOk = (state == Done) & ~errFlag & respOk;
  assign smiReqValid  = injOutValid & ~srst;
  assign smiRespStop  = srst;
  assign unusedIssued = ^issued;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= Idle;
      addr      <= '0;
      remaining <= '0;
      issued    <= '0;
      opts      <= '0;
      errFlag   <= 1'b0;
      wordCnt   <= '0;
      burstLen  <= '0;
    end else begin
      case (state)
        Idle: if (accept) begin
          addr      <= paramAddr;
          remaining <= paramLen;
          opts      <= paramOpts;
          issued    <= '0;
          errFlag   <= badParams;
          state     <= badParams ? Drain : Header;
        end
        Header: if (issue) begin
          issued   <= issued + 1'b1;
          burstLen <= burstBytes;
          wordCnt  <= '0;
          state    <= Data;
        end
        Data: if (dataTake) begin
          if ((writeEofc != 8'd0) && !finalW) begin
            errFlag <= 1'b1;
            state   <= WaitResp;
          end else if ((writeEofc == 8'd0) && finalW) begin
            errFlag <= 1'b1;
            state   <= Drain;
          end else if (lastW) begin
            addr      <= addr + 64'(burstLen);
            remaining <= remaining - 32'(burstLen);
            state     <= (remaining != 32'(burstLen)) ? Header : WaitResp;
          end else begin
            wordCnt <= wordCnt + 1'b1;
          end
        end
        Drain:    if (writeValid && (writeEofc != 8'd0)) state <= WaitResp;
        WaitResp: if (allAckedNext) state <= Done;
        Done:     if (!doneStop) state <= Idle;
        default:  state <= Idle;
      endcase
    end
  end

  smiHeaderInjectPf2 #(
    .DataBytes(DATA_BYTES), .HeaderBytes(HDR_BYTES), .FifoSize(FifoSize)
  ) uInject (
    .clk(clk), .srst(srst),
    .hdrValid(hdrValid), .hdrData(hdr), .hdrStop(hdrStop),
    .inValid(dataValid), .inEofc(injEofc), .inData(writeData), .inStop(injInStop),
    .outValid(injOutValid), .outEofc(smiReqEofc), .outData(smiReqData),
    .outStop(smiReqStop | srst)
  );

  smi_mem_lib_write_resp_tracker #(.MaxOutstanding(MaxOutstanding), .OW(OW)) uTracker (
    .clk(clk), .rstn(rstn), .issue(issue), .clrOk(accept),
    .respValid(smiRespValid & ~srst), .respEofc(smiRespEofc), .respData(smiRespData),
    .outstanding(outstanding), .allAckedNext(allAckedNext), .respOk(respOk)
  );
endmodule
